lepton_buffer_sched: RTL and testbench

//  Line-buffer scheduler between two Lepton capture writers (src0/src1) and LCD_output's reader.

---
 rtl/lepton_buffer_sched_if.sv | 49 ++++
 rtl/lepton_buffer_sched.sv | 190 +++++++++++++++++++
 tb/tb_lepton_buffer_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lepton_buffer_sched_if.sv
// rtl/lepton_buffer_sched_if.sv - Signal bundle between Lepton writers, LCD reader and the line-buffer scheduler
//
// Purpose: carries the writer handshakes, the LCD reader position and the
//          scheduler status outputs as one port of lepton_buffer_sched.
// Signals (direction seen from the scheduler, modport slave):
//   mode_in        in   2  00 src0 only, 01 src1 only, 1x alternate frames
//   req_in         in   2  per-source line-buffer request (level)
//   sof_in         in   2  per-source start-of-frame qualifier
//   done_in        in   2  per-source line-written pulse
//   rd_buff_in     in   9  buffer the LCD reader is currently on
//   err_clr_in     in   1  clears sticky error flags
//   gnt_out        out  2  one-hot grant pulse
//   wr_buff_out    out  9  granted buffer index
//   busybuff_out   out  9  buffer being written
//   filledbuff_out out  9  last committed buffer
//   fsync_out      out  1  first line of a frame committed
//   owner_out      out  1  source owning the current/last frame
//   overrun_out    out  1  sticky frame-restart error
//   timeout_out    out  1  sticky write-timeout error
// Modports: slave = scheduler, master = writers/reader side.

interface lepton_buffer_sched_if;
    logic [1:0] mode_in;
    logic [1:0] req_in;
    logic [1:0] sof_in;
    logic [1:0] done_in;
    logic [8:0] rd_buff_in;
    logic       err_clr_in;
    logic [1:0] gnt_out;
    logic [8:0] wr_buff_out;
    logic [8:0] busybuff_out;
    logic [8:0] filledbuff_out;
    logic       fsync_out;
    logic       owner_out;
    logic       overrun_out;
    logic       timeout_out;

    modport slave (
        input  mode_in, req_in, sof_in, done_in, rd_buff_in, err_clr_in,
        output gnt_out, wr_buff_out, busybuff_out, filledbuff_out,
               fsync_out, owner_out, overrun_out, timeout_out
    );

    modport master (
        output mode_in, req_in, sof_in, done_in, rd_buff_in, err_clr_in,
        input  gnt_out, wr_buff_out, busybuff_out, filledbuff_out,
               fsync_out, owner_out, overrun_out, timeout_out
    );
endinterface

// File: rtl/lepton_buffer_sched.sv
// rtl/lepton_buffer_sched.sv - Line-buffer ring scheduler between two Lepton writers and the LCD reader
//
// Purpose: hands out one line buffer at a time from a ring of NBUFFERS to the
//          source that owns the current frame, tracks committed lines, and
//          drives busybuff/filledbuff/fsync for the LCD reader. A buffer the
//          reader is still on is never granted mid-frame.
// Ports:
//   clk_in      in  1  clock
//   reset_n_in  in  1  asynchronous active-low reset
//   bus         lepton_buffer_sched_if.slave (requests, reader position, status)
// Parameters:
//   NBUFFERS  ring size (2..512)
//   VSIZE     lines per displayed frame (1..511)
//   TO_W      timeout counter width
//   TIMEOUT   max WRITE cycles from grant to done before the frame is aborted

module lepton_buffer_sched #(
    parameter int              NBUFFERS = 4,
    parameter int              VSIZE    = 240,
    parameter int              TO_W     = 23,
    parameter logic [TO_W-1:0] TIMEOUT  = 23'd60000
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    lepton_buffer_sched_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_COMMIT  = 3'd3;
    localparam logic [2:0] S_WAITREQ = 3'd4;

    localparam logic [8:0]      LAST_BUF  = 9'(NBUFFERS - 1);
    localparam logic [8:0]      LAST_LINE = 9'(VSIZE - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TIMEOUT - TO_W'(1);

    logic [2:0]      r_state;
    logic [8:0]      r_wp;
    logic [8:0]      r_line_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_owner;
    logic            r_pref;
    logic            r_alt;
    logic [1:0]      r_gnt;
    logic [8:0]      r_wr_buff;
    logic [8:0]      r_busybuff;
    logic [8:0]      r_filledbuff;
    logic            r_fsync;
    logic            r_overrun;
    logic            r_timeout;

    logic [1:0]      w_elig;
    logic [1:0]      w_start;
    logic            w_start_src;
    logic            w_own_req;
    logic            w_own_sof;
    logic            w_own_done;
    logic [1:0]      w_own_gnt;
    logic [8:0]      w_wp_next;

    // Sources allowed to open a new frame; only consulted in IDLE.
    always_comb begin
        w_elig = 2'b11;
        case (bus.mode_in)
            2'b00:   w_elig = 2'b01;
            2'b01:   w_elig = 2'b10;
            default: w_elig = 2'b11;
        endcase
    end

    assign w_start     = bus.req_in & bus.sof_in & w_elig;
    // Contention between both sources resolves to the preferred one.
    assign w_start_src = (w_start == 2'b11) ? r_pref : w_start[1];
    assign w_own_req   = bus.req_in[r_owner];
    assign w_own_sof   = bus.sof_in[r_owner];
    assign w_own_done  = bus.done_in[r_owner];
    assign w_own_gnt   = r_owner ? 2'b10 : 2'b01;
    assign w_wp_next   = (r_wp == LAST_BUF) ? 9'd0 : r_wp + 9'd1;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state      <= S_IDLE;
            r_wp         <= 9'd0;
            r_line_cnt   <= 9'd0;
            r_to_cnt     <= '0;
            r_owner      <= 1'b0;
            r_pref       <= 1'b0;
            r_alt        <= 1'b0;
            r_gnt        <= 2'b00;
            r_wr_buff    <= 9'd0;
            r_busybuff   <= 9'd0;
            r_filledbuff <= 9'd0;
            r_fsync      <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_gnt   <= 2'b00;
            r_fsync <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (bus.err_clr_in) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (|w_start) begin
                        r_state    <= S_GRANT;
                        r_owner    <= w_start_src;
                        r_alt      <= bus.mode_in[1];
                        r_wp       <= 9'd0;
                        r_line_cnt <= 9'd0;
                        r_to_cnt   <= '0;
                        r_gnt      <= w_start_src ? 2'b10 : 2'b01;
                        r_wr_buff  <= 9'd0;
                        r_busybuff <= 9'd0;
                    end
                end

                S_GRANT: begin
                    r_state <= S_WRITE;
                end

                S_WRITE: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (w_own_done) begin
                        r_state <= S_COMMIT;
                    end else if (r_to_cnt == TO_LAST) begin
                        // Abort the frame; the reader keeps the last good buffer.
                        r_timeout  <= 1'b1;
                        r_state    <= S_IDLE;
                        r_busybuff <= r_filledbuff;
                    end
                end

                S_COMMIT: begin
                    r_filledbuff <= r_wp;
                    r_busybuff   <= r_wp;
                    r_wp         <= w_wp_next;
                    r_line_cnt   <= r_line_cnt + 9'd1;
                    r_fsync      <= (r_line_cnt == 9'd0);
                    if (r_line_cnt == LAST_LINE) begin
                        r_state <= S_IDLE;
                        if (r_alt) begin
                            r_pref <= ~r_owner;
                        end
                    end else begin
                        r_state <= S_WAITREQ;
                    end
                end

                S_WAITREQ: begin
                    if (w_own_req && w_own_sof) begin
                        // Owner restarted its frame early: start over at buffer 0
                        // without waiting for the reader.
                        r_overrun  <= 1'b1;
                        r_wp       <= 9'd0;
                        r_line_cnt <= 9'd0;
                        r_to_cnt   <= '0;
                        r_gnt      <= w_own_gnt;
                        r_wr_buff  <= 9'd0;
                        r_busybuff <= 9'd0;
                        r_state    <= S_GRANT;
                    end else if (w_own_req && (r_wp != bus.rd_buff_in)) begin
                        r_to_cnt   <= '0;
                        r_gnt      <= w_own_gnt;
                        r_wr_buff  <= r_wp;
                        r_busybuff <= r_wp;
                        r_state    <= S_GRANT;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_out        = r_gnt;
    assign bus.wr_buff_out    = r_wr_buff;
    assign bus.busybuff_out   = r_busybuff;
    assign bus.filledbuff_out = r_filledbuff;
    assign bus.fsync_out      = r_fsync;
    assign bus.owner_out      = r_owner;
    assign bus.overrun_out    = r_overrun;
    assign bus.timeout_out    = r_timeout;

endmodule

// File: tb/tb_lepton_buffer_sched.sv
// tb/tb_lepton_buffer_sched.sv - Self-checking bench for lepton_buffer_sched (NBUFFERS=2, VSIZE=4, TIMEOUT=20)

module tb_lepton_buffer_sched;

    typedef struct packed {
        logic [1:0] gnt;
        logic [8:0] buff;
    } exp_t;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         failures;
    exp_t       sb[$];
    exp_t       e;
    logic [8:0] exp_fb;
    bit         seen;
    int         n;
    logic [8:0] fb_mid;

    lepton_buffer_sched_if bus();

    lepton_buffer_sched #(
        .NBUFFERS(2),
        .VSIZE   (4),
        .TO_W    (23),
        .TIMEOUT (23'd20)
    ) dut (
        .clk_in    (clk),
        .reset_n_in(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [8:0] b);
        exp_t x;
        x.gnt  = g;
        x.buff = b;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input int budget, output bit s, output int k);
        s = 0;
        k = 0;
        while (!s && k < budget) begin
            tick();
            k++;
            if (bus.gnt_out != 2'b00) s = 1;
        end
    endtask

    task automatic line_req(input int src, input bit sof, output bit s, output int k);
        bus.req_in[src] = 1'b1;
        bus.sof_in[src] = sof;
        wait_gnt(8, s, k);
        bus.req_in[src] = 1'b0;
        bus.sof_in[src] = 1'b0;
    endtask

    // GRANT -> WRITE, then a one-cycle done pulse; mid is filledbuff one cycle after done.
    task automatic line_done(input int src, output logic [8:0] mid);
        tick();
        bus.done_in[src] = 1'b1;
        tick();
        bus.done_in[src] = 1'b0;
        mid = bus.filledbuff_out;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.gnt_out, bus.wr_buff_out, bus.busybuff_out, bus.filledbuff_out, bus.fsync_out,
             bus.owner_out, bus.overrun_out, bus.timeout_out} !== 33'd0) begin
            failures++;
            $display("FAIL reset_hold outputs=%h required 0", {bus.gnt_out, bus.wr_buff_out,
                     bus.busybuff_out, bus.filledbuff_out, bus.fsync_out, bus.owner_out,
                     bus.overrun_out, bus.timeout_out});
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.gnt_out, bus.wr_buff_out, bus.busybuff_out, bus.filledbuff_out, bus.fsync_out,
             bus.owner_out, bus.overrun_out, bus.timeout_out} !== 33'd0) begin
            failures++;
            $display("FAIL reset_idle outputs=%h required 0", {bus.gnt_out, bus.wr_buff_out,
                     bus.busybuff_out, bus.filledbuff_out, bus.fsync_out, bus.owner_out,
                     bus.overrun_out, bus.timeout_out});
        end
        exp_fb = 9'd0;
    endtask

    task automatic test_frame_src0();
        bus.mode_in = 2'b00;
        for (int l = 0; l < 4; l++) begin
            bus.rd_buff_in = bus.filledbuff_out;
            push_exp(2'b01, 9'(l % 2));
            line_req(0, (l == 0), seen, n);
            e = sb.pop_front();
            checks++;
            if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff ||
                bus.busybuff_out !== e.buff || bus.owner_out !== 1'b0) begin
                failures++;
                $display("FAIL frame_grant line=%0d seen=%0d gnt=%b wr=%0d busy=%0d owner=%b required gnt=%b buff=%0d owner=0",
                         l, seen, bus.gnt_out, bus.wr_buff_out, bus.busybuff_out, bus.owner_out, e.gnt, e.buff);
            end
            if (l == 0) begin
                checks++;
                if (n !== 1) begin
                    failures++;
                    $display("FAIL frame_latency cycles=%0d required 1", n);
                end
            end
            line_done(0, fb_mid);
            checks++;
            if (fb_mid !== exp_fb || bus.filledbuff_out !== 9'(l % 2) ||
                bus.busybuff_out !== 9'(l % 2) || bus.fsync_out !== (l == 0)) begin
                failures++;
                $display("FAIL frame_commit line=%0d mid=%0d filled=%0d busy=%0d fsync=%b required mid=%0d filled=%0d fsync=%0d",
                         l, fb_mid, bus.filledbuff_out, bus.busybuff_out, bus.fsync_out, exp_fb, l % 2, (l == 0));
            end
            exp_fb = 9'(l % 2);
        end
        bus.req_in[0] = 1'b1;
        wait_gnt(5, seen, n);
        bus.req_in[0] = 1'b0;
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL frame_idle gnt=%b after frame end without sof, required no grant", bus.gnt_out);
        end
    endtask

    task automatic test_rd_hold();
        bus.mode_in = 2'b00;
        push_exp(2'b01, 9'd0);
        line_req(0, 1'b1, seen, n);
        e = sb.pop_front();
        checks++;
        if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
            failures++;
            $display("FAIL hold_first seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                     seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
        end
        line_done(0, fb_mid);
        exp_fb = 9'd0;
        bus.rd_buff_in = 9'd1;
        bus.req_in[0]  = 1'b1;
        wait_gnt(6, seen, n);
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL hold_nogrant gnt=%b while reader on wp=1, required no grant", bus.gnt_out);
        end
        bus.rd_buff_in = 9'd0;
        push_exp(2'b01, 9'd1);
        wait_gnt(2, seen, n);
        bus.req_in[0] = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n !== 1 || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
            failures++;
            $display("FAIL hold_grant seen=%0d cycles=%0d gnt=%b wr=%0d required cycles=1 gnt=%b buff=%0d",
                     seen, n, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
        end
        line_done(0, fb_mid);
        exp_fb = 9'd1;
        for (int l = 2; l < 4; l++) begin
            bus.rd_buff_in = bus.filledbuff_out;
            push_exp(2'b01, 9'(l % 2));
            line_req(0, 1'b0, seen, n);
            e = sb.pop_front();
            checks++;
            if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
                failures++;
                $display("FAIL hold_rest line=%0d seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                         l, seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
            end
            line_done(0, fb_mid);
            exp_fb = 9'(l % 2);
        end
    endtask

    task automatic test_alternate();
        bus.mode_in = 2'b10;
        for (int s = 0; s < 2; s++) begin
            bus.req_in = 2'b11;
            bus.sof_in = 2'b11;
            push_exp((s == 0) ? 2'b01 : 2'b10, 9'd0);
            wait_gnt(4, seen, n);
            e = sb.pop_front();
            checks++;
            if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff || bus.owner_out !== s[0]) begin
                failures++;
                $display("FAIL alt_start src=%0d seen=%0d gnt=%b wr=%0d owner=%b required gnt=%b buff=%0d owner=%0d",
                         s, seen, bus.gnt_out, bus.wr_buff_out, bus.owner_out, e.gnt, e.buff, s);
            end
            // The other source keeps requesting with sof throughout the frame.
            bus.req_in[s] = 1'b0;
            bus.sof_in[s] = 1'b0;
            line_done(s, fb_mid);
            exp_fb = 9'd0;
            for (int l = 1; l < 4; l++) begin
                bus.rd_buff_in = bus.filledbuff_out;
                push_exp((s == 0) ? 2'b01 : 2'b10, 9'(l % 2));
                line_req(s, 1'b0, seen, n);
                e = sb.pop_front();
                checks++;
                if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
                    failures++;
                    $display("FAIL alt_line src=%0d line=%0d seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                             s, l, seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
                end
                line_done(s, fb_mid);
                exp_fb = 9'(l % 2);
            end
        end
        bus.req_in = 2'b00;
        bus.sof_in = 2'b00;
    endtask

    task automatic test_timeout();
        bus.mode_in = 2'b00;
        push_exp(2'b01, 9'd0);
        line_req(0, 1'b1, seen, n);
        e = sb.pop_front();
        checks++;
        if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
            failures++;
            $display("FAIL to_grant seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                     seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
        end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (bus.timeout_out !== 1'b0) begin
            failures++;
            $display("FAIL to_early timeout=%b required 0", bus.timeout_out);
        end
        tick();
        checks++;
        if (bus.timeout_out !== 1'b1 || bus.filledbuff_out !== exp_fb || bus.busybuff_out !== exp_fb) begin
            failures++;
            $display("FAIL to_set timeout=%b filled=%0d busy=%0d required timeout=1 filled=%0d busy=%0d",
                     bus.timeout_out, bus.filledbuff_out, bus.busybuff_out, exp_fb, exp_fb);
        end
        bus.err_clr_in = 1'b1;
        tick();
        bus.err_clr_in = 1'b0;
        checks++;
        if (bus.timeout_out !== 1'b0) begin
            failures++;
            $display("FAIL to_clr timeout=%b required 0", bus.timeout_out);
        end
    endtask

    task automatic test_overrun_reset();
        bus.mode_in = 2'b00;
        for (int l = 0; l < 3; l++) begin
            bus.rd_buff_in = bus.filledbuff_out;
            push_exp(2'b01, 9'(l % 2));
            line_req(0, (l == 0), seen, n);
            e = sb.pop_front();
            checks++;
            if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
                failures++;
                $display("FAIL ovr_line line=%0d seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                         l, seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
            end
            line_done(0, fb_mid);
            exp_fb = 9'(l % 2);
        end
        // wp is 1 here; the restart must ignore the reader sitting on buffer 0.
        bus.rd_buff_in = 9'd0;
        bus.req_in[0]  = 1'b1;
        bus.sof_in[0]  = 1'b1;
        bus.err_clr_in = 1'b1;
        push_exp(2'b01, 9'd0);
        wait_gnt(3, seen, n);
        bus.req_in[0]  = 1'b0;
        bus.sof_in[0]  = 1'b0;
        bus.err_clr_in = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || n !== 1 || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff || bus.overrun_out !== 1'b1) begin
            failures++;
            $display("FAIL ovr_restart seen=%0d cycles=%0d gnt=%b wr=%0d overrun=%b required cycles=1 gnt=%b buff=%0d overrun=1",
                     seen, n, bus.gnt_out, bus.wr_buff_out, bus.overrun_out, e.gnt, e.buff);
        end
        line_done(0, fb_mid);
        checks++;
        if (bus.fsync_out !== 1'b1 || bus.filledbuff_out !== 9'd0) begin
            failures++;
            $display("FAIL ovr_fsync fsync=%b filled=%0d required fsync=1 filled=0", bus.fsync_out, bus.filledbuff_out);
        end
        bus.err_clr_in = 1'b1;
        tick();
        bus.err_clr_in = 1'b0;
        checks++;
        if (bus.overrun_out !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clr overrun=%b required 0", bus.overrun_out);
        end
        bus.rd_buff_in = 9'd0;
        push_exp(2'b01, 9'd1);
        line_req(0, 1'b0, seen, n);
        e = sb.pop_front();
        checks++;
        if (!seen || bus.gnt_out !== e.gnt || bus.wr_buff_out !== e.buff) begin
            failures++;
            $display("FAIL ovr_next seen=%0d gnt=%b wr=%0d required gnt=%b buff=%0d",
                     seen, bus.gnt_out, bus.wr_buff_out, e.gnt, e.buff);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt_out, bus.wr_buff_out, bus.busybuff_out, bus.filledbuff_out, bus.fsync_out,
             bus.owner_out, bus.overrun_out, bus.timeout_out} !== 33'd0) begin
            failures++;
            $display("FAIL reset_mid outputs=%h required 0", {bus.gnt_out, bus.wr_buff_out,
                     bus.busybuff_out, bus.filledbuff_out, bus.fsync_out, bus.owner_out,
                     bus.overrun_out, bus.timeout_out});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.gnt_out, bus.busybuff_out, bus.filledbuff_out, bus.fsync_out} !== 20'd0) begin
            failures++;
            $display("FAIL reset_after gnt=%b busy=%0d filled=%0d fsync=%b required 0",
                     bus.gnt_out, bus.busybuff_out, bus.filledbuff_out, bus.fsync_out);
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst_n          = 1'b0;
        checks         = 0;
        failures       = 0;
        exp_fb         = 9'd0;
        bus.mode_in    = 2'b00;
        bus.req_in     = 2'b00;
        bus.sof_in     = 2'b00;
        bus.done_in    = 2'b00;
        bus.rd_buff_in = 9'd0;
        bus.err_clr_in = 1'b0;
        tick();
        test_reset();
        test_frame_src0();
        test_rd_hold();
        test_alternate();
        test_timeout();
        test_overrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
